// File: rtl/core_regfile_pkg.sv
// core_regfile_pkg: shared defaults, address-width helper and types for the register file
package core_regfile_pkg;
    function automatic int aw_of(int n);
        return n > 1 ? $clog2(n) : 1;
    endfunction
    localparam int XLEN_DEF = 32;
    localparam int NREG_DEF = 32;
    localparam int AW_DEF = aw_of(NREG_DEF);
    typedef logic [AW_DEF-1:0] reg_addr_t;
    typedef logic [XLEN_DEF-1:0] word_t;
endpackage

// File: rtl/core_regfile_sb_if.sv
// core_regfile_sb_if: read, write, issue and scoreboard signals of the register file
interface core_regfile_sb_if import core_regfile_pkg::*; #(
    parameter int XLEN = XLEN_DEF,
    parameter int NREG = NREG_DEF,
    parameter int NRD = 2,
    parameter int NWR = 3
);
    localparam int AW = aw_of(NREG);
    logic i_hold;
    logic [NRD-1:0] i_re;
    logic [NRD-1:0][AW-1:0] i_raddr;
    logic [NRD-1:0][XLEN-1:0] o_rdata;
    logic [NRD-1:0] o_rbusy;
    logic [NWR-1:0] i_we;
    logic [NWR-1:0][AW-1:0] i_waddr;
    logic [NWR-1:0][XLEN-1:0] i_wdata;
    logic i_iss_vld;
    logic [AW-1:0] i_iss_addr;
    logic i_flush;
    logic [NREG-1:0] o_busy_vec;
    modport master (
        output i_hold, i_re, i_raddr, i_we, i_waddr, i_wdata, i_iss_vld, i_iss_addr, i_flush,
        input o_rdata, o_rbusy, o_busy_vec
    );
    modport slave (
        input i_hold, i_re, i_raddr, i_we, i_waddr, i_wdata, i_iss_vld, i_iss_addr, i_flush,
        output o_rdata, o_rbusy, o_busy_vec
    );
endinterface

// File: rtl/core_regfile_rdport.sv
// core_regfile_rdport: one registered read port with write forwarding, zero/range check and hold
module core_regfile_rdport import core_regfile_pkg::*; #(
    parameter int XLEN = XLEN_DEF,
    parameter int NREG = NREG_DEF,
    parameter int NWR = 3,
    parameter int ZERO_R0 = 1,
    parameter int AW = aw_of(NREG)
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      hold,
    input  logic                      re,
    input  logic [AW-1:0]             raddr,
    input  logic [NWR-1:0]            we,
    input  logic [NWR-1:0][AW-1:0]    waddr,
    input  logic [NWR-1:0][XLEN-1:0]  wdata,
    input  logic [NREG-1:0][XLEN-1:0] regs,
    input  logic [NREG-1:0]           busy,
    output logic [XLEN-1:0]           rdata,
    output logic                      rbusy
);
    logic valid, fhit;
    logic [XLEN-1:0] fdata;
    assign valid = re && int'(raddr) < NREG && !(ZERO_R0 != 0 && raddr == '0);
    // Descending scan so the lowest-indexed writer is the one left standing
    always_comb begin
        fhit = 1'b0;
        fdata = regs[raddr];
        for (int p = NWR - 1; p >= 0; p--)
            if (we[p] && waddr[p] == raddr) begin
                fhit = 1'b1;
                fdata = wdata[p];
            end
    end
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            rdata <= '0;
            rbusy <= 1'b0;
        end else if (!hold) begin
            rdata <= valid ? fdata : '0;
            rbusy <= valid && busy[raddr] && !fhit;
        end
endmodule

// File: rtl/core_regfile_sb.sv
// core_regfile_sb: multi-port register file with fixed-priority writes and a write-pending scoreboard
module core_regfile_sb import core_regfile_pkg::*; #(
    parameter int XLEN = XLEN_DEF,
    parameter int NREG = NREG_DEF,
    parameter int NRD = 2,
    parameter int NWR = 3,
    parameter int ZERO_R0 = 1
) (
    input logic clk,
    input logic rst_n,
    core_regfile_sb_if.slave bus
);
    localparam int AW = aw_of(NREG);
    logic [NREG-1:0][XLEN-1:0] regs;
    logic [NREG-1:0] busy_q;
    for (genvar r = 0; r < NREG; r++) begin : g_reg
        localparam bit ZR = (ZERO_R0 != 0) && (r == 0);
        logic hit, bq;
        logic [XLEN-1:0] wd, q;
        always_comb begin
            hit = 1'b0;
            wd = '0;
            for (int p = NWR - 1; p >= 0; p--)
                if (bus.i_we[p] && bus.i_waddr[p] == AW'(r) && !ZR) begin
                    hit = 1'b1;
                    wd = bus.i_wdata[p];
                end
        end
        // Issue set outranks both writeback clear and flush
        always_ff @(posedge clk or negedge rst_n)
            if (!rst_n) begin
                q <= '0;
                bq <= 1'b0;
            end else begin
                if (hit) q <= wd;
                bq <= (bus.i_iss_vld && bus.i_iss_addr == AW'(r) && !ZR) ? 1'b1 :
                      (bus.i_flush || hit) ? 1'b0 : bq;
            end
        assign regs[r] = q;
        assign busy_q[r] = bq;
    end
    assign bus.o_busy_vec = busy_q;
    for (genvar i = 0; i < NRD; i++) begin : g_rd
        core_regfile_rdport #(
            .XLEN(XLEN), .NREG(NREG), .NWR(NWR), .ZERO_R0(ZERO_R0), .AW(AW)
        ) u_rd (
            .clk   (clk),
            .rst_n (rst_n),
            .hold  (bus.i_hold),
            .re    (bus.i_re[i]),
            .raddr (bus.i_raddr[i]),
            .we    (bus.i_we),
            .waddr (bus.i_waddr),
            .wdata (bus.i_wdata),
            .regs  (regs),
            .busy  (busy_q),
            .rdata (bus.o_rdata[i]),
            .rbusy (bus.o_rbusy[i])
        );
    end
endmodule

// File: tb/tb_core_regfile_sb.sv
// tb_core_regfile_sb: random and directed stimulus against a behavioural register-file model with a scoreboard
module tb_core_regfile_sb;
    import core_regfile_pkg::*;
    localparam int XLEN = 32;
    localparam int NREG = 32;
    localparam int NRD = 2;
    localparam int NWR = 3;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;
    core_regfile_sb_if #(.XLEN(XLEN), .NREG(NREG), .NRD(NRD), .NWR(NWR)) bus();
    core_regfile_sb #(.XLEN(XLEN), .NREG(NREG), .NRD(NRD), .NWR(NWR), .ZERO_R0(1)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );
    typedef struct {
        logic [NRD-1:0][XLEN-1:0] d;
        logic [NRD-1:0] b;
        logic [NREG-1:0] bv;
    } exp_t;
    exp_t q[$];
    exp_t m;
    int checks = 0;
    int errors = 0;
    word_t mem[NREG];
    logic [NREG-1:0] busy;
    logic [NRD-1:0][XLEN-1:0] od;
    logic [NRD-1:0] ob;
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask
    task automatic idle();
        bus.i_hold = 1'b0;
        bus.i_re = '0;
        bus.i_raddr = '0;
        bus.i_we = '0;
        bus.i_waddr = '0;
        bus.i_wdata = '0;
        bus.i_iss_vld = 1'b0;
        bus.i_iss_addr = '0;
        bus.i_flush = 1'b0;
    endtask
    task automatic model_reset();
        foreach (mem[r]) mem[r] = '0;
        busy = '0;
        od = '0;
        ob = '0;
    endtask
    // Called at a falling edge with inputs set; predicts, crosses one rising edge, returns at the next falling edge
    task automatic step();
        exp_t e;
        bit wr[NREG];
        word_t wv[NREG];
        int a;
        for (int p = 0; p < NWR; p++) begin
            a = int'(bus.i_waddr[p]);
            if (bus.i_we[p] && a != 0 && !wr[a]) begin
                wr[a] = 1'b1;
                wv[a] = bus.i_wdata[p];
            end
        end
        for (int i = 0; i < NRD; i++) begin
            a = int'(bus.i_raddr[i]);
            if (bus.i_hold) begin
                e.d[i] = od[i];
                e.b[i] = ob[i];
            end else if (!bus.i_re[i] || a == 0) begin
                e.d[i] = '0;
                e.b[i] = 1'b0;
            end else begin
                e.d[i] = wr[a] ? wv[a] : mem[a];
                e.b[i] = busy[a] && !wr[a];
            end
        end
        e.bv = busy;
        for (int r = 0; r < NREG; r++) if (wr[r]) e.bv[r] = 1'b0;
        if (bus.i_flush) e.bv = '0;
        if (bus.i_iss_vld && bus.i_iss_addr != '0) e.bv[bus.i_iss_addr] = 1'b1;
        q.push_back(e);
        @(posedge clk);
        for (int r = 0; r < NREG; r++) if (wr[r]) mem[r] = wv[r];
        busy = e.bv;
        od = e.d;
        ob = e.b;
        @(negedge clk);
    endtask
    initial forever begin
        @(posedge clk);
        #1;
        if (q.size() > 0) begin
            m = q.pop_front();
            for (int i = 0; i < NRD; i++) begin
                chk($sformatf("rdata%0d", i), bus.o_rdata[i], m.d[i]);
                chk($sformatf("rbusy%0d", i), 32'(bus.o_rbusy[i]), 32'(m.b[i]));
            end
            chk("busy_vec", bus.o_busy_vec, m.bv);
        end
    end
    initial begin
        idle();
        model_reset();
        #2;
        chk("rst_rdata0", bus.o_rdata[0], 32'h0);
        chk("rst_busy_vec", bus.o_busy_vec, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        bus.i_re = 2'b11;
        bus.i_raddr[0] = 5'd1;
        bus.i_raddr[1] = 5'd5;
        step();
        chk("rd_r1", bus.o_rdata[0], 32'h0);
        chk("rd_r5_busy", 32'(bus.o_rbusy[1]), 32'h0);
        idle();
        bus.i_we[0] = 1'b1;
        bus.i_waddr[0] = 5'd0;
        bus.i_wdata[0] = 32'hDEAD;
        step();
        idle();
        bus.i_re = 2'b01;
        bus.i_raddr[0] = 5'd0;
        step();
        chk("r0_zero", bus.o_rdata[0], 32'h0);
        idle();
        bus.i_we = 3'b111;
        bus.i_waddr[0] = 5'd7;
        bus.i_waddr[1] = 5'd7;
        bus.i_waddr[2] = 5'd7;
        bus.i_wdata[0] = 32'h11;
        bus.i_wdata[1] = 32'h22;
        bus.i_wdata[2] = 32'h33;
        bus.i_re = 2'b01;
        bus.i_raddr[0] = 5'd7;
        step();
        chk("fwd_prio", bus.o_rdata[0], 32'h11);
        idle();
        bus.i_re = 2'b01;
        bus.i_raddr[0] = 5'd7;
        step();
        chk("r7_stored", bus.o_rdata[0], 32'h11);
        idle();
        bus.i_iss_vld = 1'b1;
        bus.i_iss_addr = 5'd3;
        step();
        idle();
        step();
        step();
        bus.i_re = 2'b01;
        bus.i_raddr[0] = 5'd3;
        step();
        chk("r3_busy", 32'(bus.o_rbusy[0]), 32'h1);
        idle();
        bus.i_we[2] = 1'b1;
        bus.i_waddr[2] = 5'd3;
        bus.i_wdata[2] = 32'h55;
        bus.i_re = 2'b01;
        bus.i_raddr[0] = 5'd3;
        step();
        chk("r3_wb_data", bus.o_rdata[0], 32'h55);
        chk("r3_wb_busy", 32'(bus.o_rbusy[0]), 32'h0);
        chk("r3_vec", 32'(bus.o_busy_vec[3]), 32'h0);
        idle();
        bus.i_iss_vld = 1'b1;
        bus.i_iss_addr = 5'd4;
        step();
        idle();
        bus.i_we[0] = 1'b1;
        bus.i_waddr[0] = 5'd4;
        bus.i_wdata[0] = 32'h44;
        bus.i_iss_vld = 1'b1;
        bus.i_iss_addr = 5'd4;
        step();
        chk("set_over_clear", 32'(bus.o_busy_vec[4]), 32'h1);
        idle();
        bus.i_iss_vld = 1'b1;
        bus.i_iss_addr = 5'd10;
        step();
        idle();
        bus.i_flush = 1'b1;
        bus.i_iss_vld = 1'b1;
        bus.i_iss_addr = 5'd9;
        step();
        chk("flush_issue", bus.o_busy_vec, 32'h200);
        idle();
        bus.i_we[0] = 1'b1;
        bus.i_waddr[0] = 5'd2;
        bus.i_wdata[0] = 32'hAA;
        step();
        idle();
        bus.i_re = 2'b01;
        bus.i_raddr[0] = 5'd2;
        step();
        chk("r2_aa", bus.o_rdata[0], 32'hAA);
        for (int k = 0; k < 3; k++) begin
            idle();
            bus.i_hold = 1'b1;
            bus.i_re = 2'b11;
            bus.i_raddr[0] = 5'd2;
            bus.i_we[1] = 1'b1;
            bus.i_waddr[1] = 5'd2;
            bus.i_wdata[1] = 32'hBB;
            step();
            chk("hold_data", bus.o_rdata[0], 32'hAA);
        end
        idle();
        bus.i_re = 2'b01;
        bus.i_raddr[0] = 5'd2;
        step();
        chk("r2_bb", bus.o_rdata[0], 32'hBB);
        for (int k = 0; k < 400; k++) begin
            bus.i_hold = ($urandom_range(0, 9) == 0);
            bus.i_re = 2'($urandom);
            for (int i = 0; i < NRD; i++) bus.i_raddr[i] = 5'($urandom_range(0, 15));
            bus.i_we = 3'($urandom);
            for (int p = 0; p < NWR; p++) begin
                bus.i_waddr[p] = 5'($urandom_range(0, 15));
                bus.i_wdata[p] = $urandom;
            end
            bus.i_iss_vld = 1'($urandom);
            bus.i_iss_addr = 5'($urandom_range(0, 15));
            bus.i_flush = ($urandom_range(0, 15) == 0);
            step();
        end
        idle();
        bus.i_iss_vld = 1'b1;
        bus.i_iss_addr = 5'd12;
        bus.i_we[0] = 1'b1;
        bus.i_waddr[0] = 5'd13;
        bus.i_wdata[0] = $urandom | 32'h1;
        bus.i_re = 2'b11;
        bus.i_raddr[0] = 5'd7;
        bus.i_raddr[1] = 5'd13;
        step();
        idle();
        #2;
        rst_n = 1'b0;
        #1;
        for (int i = 0; i < NRD; i++) begin
            chk($sformatf("async_rst_rdata%0d", i), bus.o_rdata[i], 32'h0);
            chk($sformatf("async_rst_rbusy%0d", i), 32'(bus.o_rbusy[i]), 32'h0);
        end
        chk("async_rst_busy_vec", bus.o_busy_vec, 32'h0);
        #1;
        rst_n = 1'b1;
        model_reset();
        @(negedge clk);
        bus.i_re = 2'b11;
        bus.i_raddr[0] = 5'd7;
        bus.i_raddr[1] = 5'd13;
        step();
        chk("post_rst_r7", bus.o_rdata[0], 32'h0);
        chk("post_rst_r13", bus.o_rdata[1], 32'h0);
        idle();
        step();
        chk("queue_drain", 32'(q.size()), 32'h0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
